bin_col_buffer5: RTL and testbench



---
 rtl/bin_col_buf_pkg.sv | 25 ++
 rtl/bin_col_buffer5_ram.sv | 29 ++
 rtl/bin_col_buffer5.sv | 171 +++++++++++++++++
 tb/tb_bin_col_buffer5.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/bin_col_buf_pkg.sv
// Shared types and helpers for the binary column buffer: column geometry,
// FSM encoding and the row-existence mask used for top-of-frame padding.
package bin_col_buf_pkg;

  localparam int COL_H = 5;
  localparam int HIST  = COL_H - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Bit k is set when row y-k lies inside the frame (k <= y).
  function automatic logic [COL_H-1:0] pad_mask(input logic [31:0] y);
    logic [COL_H-1:0] m;
    m = {COL_H{1'b0}};
    for (int k = 0; k < COL_H; k++) begin
      m[k] = (y >= 32'(k));
    end
    return m;
  endfunction

endpackage

// File: rtl/bin_col_buffer5_ram.sv
// Simple dual-port line RAM, synchronous read and write; kept on its own so
// block-RAM inference is not disturbed by the surrounding control logic.
module bin_line_ram #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 4,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Storage array and registered read port; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem_r[rd_addr];
    end
  end

endmodule

// File: rtl/bin_col_buffer5.sv
// Line-buffered 5-row column generator for the 1-bit pixel path.
// Optional macro BIN_COL_BUF_PAD_ONES_EN: pad rows above the frame top with 1s instead of 0s.
module bin_col_buffer5
  import bin_col_buf_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int X_W   = 10,
  parameter int Y_W   = 9
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           frame_start,
  input  logic           pix_valid,
  input  logic           pix_in,
  output logic [4:0]     col_out,
  output logic           col_valid,
  output logic [X_W-1:0] col_x,
  output logic [Y_W-1:0] col_y,
  output logic           win_full,
  output logic           frame_done
);

  state_t           state_r, state_s, base_s;
  logic [X_W-1:0]   x_r, x_s, acc_x_s;
  logic [Y_W-1:0]   y_r, y_s, acc_y_s;
  logic             accept_s, line_end_s, frame_end_s;

  logic             s1_valid_r, s1_pix_r, s1_last_r;
  logic [X_W-1:0]   s1_x_r;
  logic [Y_W-1:0]   s1_y_r;

  logic [HIST-1:0]  ram_rd_s;
  logic [COL_H-1:0] col_raw_s, mask_s, col_pad_s;

  logic [4:0]       col_out_r;
  logic             col_valid_r, win_full_r, frame_done_r;
  logic [X_W-1:0]   col_x_r;
  logic [Y_W-1:0]   col_y_r;

  // Acceptance, counter advance and FSM next state; frame_start restarts at (0,0) in any state.
  always_comb begin
    base_s      = frame_start ? FILL : state_r;
    acc_x_s     = frame_start ? {X_W{1'b0}} : x_r;
    acc_y_s     = frame_start ? {Y_W{1'b0}} : y_r;
    accept_s    = pix_valid && ((base_s == FILL) || (base_s == RUN));
    line_end_s  = (acc_x_s == X_W'(IMG_W - 1));
    frame_end_s = line_end_s && (acc_y_s == Y_W'(IMG_H - 1));
    x_s         = acc_x_s;
    y_s         = acc_y_s;
    state_s     = base_s;
    if (accept_s) begin
      if (line_end_s) begin
        x_s = {X_W{1'b0}};
        y_s = acc_y_s + Y_W'(1);
      end else begin
        x_s = acc_x_s + X_W'(1);
        y_s = acc_y_s;
      end
    end else begin
      x_s = acc_x_s;
      y_s = acc_y_s;
    end
    case (base_s)
      IDLE: state_s = IDLE;
      FILL: begin
        if (accept_s && line_end_s && (acc_y_s == Y_W'(HIST - 1))) begin
          state_s = RUN;
        end else begin
          state_s = FILL;
        end
      end
      RUN: begin
        if (accept_s && frame_end_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE:    state_s = DONE;
      default: state_s = IDLE;
    endcase
  end

  // FSM state and pixel position counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      x_r     <= {X_W{1'b0}};
      y_r     <= {Y_W{1'b0}};
    end else begin
      state_r <= state_s;
      x_r     <= x_s;
      y_r     <= y_s;
    end
  end

  // Stage 1: hold the accepted pixel and its position while the RAM read completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_pix_r   <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_x_r     <= {X_W{1'b0}};
      s1_y_r     <= {Y_W{1'b0}};
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_pix_r  <= pix_in;
        s1_last_r <= frame_end_s;
        s1_x_r    <= acc_x_s;
        s1_y_r    <= acc_y_s;
      end
    end
  end

  // Write-back shifts the new pixel into the history word one cycle after its read.
  bin_line_ram #(
    .DEPTH (IMG_W),
    .WIDTH (HIST),
    .AW    (X_W)
  ) u_line_ram (
    .clk     (clk),
    .wr_en   (s1_valid_r),
    .wr_addr (s1_x_r),
    .wr_data ({ram_rd_s[HIST-2:0], s1_pix_r}),
    .rd_en   (accept_s),
    .rd_addr (acc_x_s),
    .rd_data (ram_rd_s)
  );

  // Hide rows above the frame top; stale RAM contents never reach the output.
  always_comb begin
    col_raw_s = {ram_rd_s, s1_pix_r};
    mask_s    = pad_mask(32'(s1_y_r));
`ifdef BIN_COL_BUF_PAD_ONES_EN
    col_pad_s = col_raw_s | ~mask_s;
`else
    col_pad_s = col_raw_s & mask_s;
`endif
  end

  // Output register; column data and position hold while no column is emitted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_out_r    <= 5'd0;
      col_valid_r  <= 1'b0;
      col_x_r      <= {X_W{1'b0}};
      col_y_r      <= {Y_W{1'b0}};
      win_full_r   <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      col_valid_r  <= s1_valid_r;
      win_full_r   <= s1_valid_r && (s1_y_r >= Y_W'(HIST));
      frame_done_r <= s1_valid_r && s1_last_r;
      if (s1_valid_r) begin
        col_out_r <= col_pad_s;
        col_x_r   <= s1_x_r;
        col_y_r   <= s1_y_r;
      end
    end
  end

  assign col_out    = col_out_r;
  assign col_valid  = col_valid_r;
  assign col_x      = col_x_r;
  assign col_y      = col_y_r;
  assign win_full   = win_full_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_bin_col_buffer5.sv
// Self-checking bench for bin_col_buffer5 on an 8x6 frame: table vectors plus a
// frame-buffer reference model feeding a scoreboard queue.
module tb_bin_col_buffer5;

  localparam int W = 8;
  localparam int H = 6;

`ifdef BIN_COL_BUF_PAD_ONES_EN
  localparam bit PAD = 1'b1;
  localparam logic [4:0] ROW0_ONES = 5'b11111;
`else
  localparam bit PAD = 1'b0;
  localparam logic [4:0] ROW0_ONES = 5'b00001;
`endif

  typedef struct packed {
    logic       v;
    logic [4:0] col;
    logic [2:0] x;
    logic [2:0] y;
    logic       full;
    logic       done;
  } exp_t;

  typedef struct packed {
    logic fs;
    logic v;
    logic p;
    exp_t e;
  } vec_t;

  logic       clk, rst, frame_start, pix_valid, pix_in;
  logic [4:0] col_out;
  logic       col_valid, win_full, frame_done;
  logic [2:0] col_x, col_y;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_cnt = 0;
  exp_t q[$];
  vec_t tbl[9];

  bit   fb[8][8];
  bit   m_act = 1'b0;
  int   m_x = 0;
  int   m_y = 0;

  bin_col_buffer5 #(.IMG_W(W), .IMG_H(H), .X_W(3), .Y_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .pix_valid   (pix_valid),
    .pix_in      (pix_in),
    .col_out     (col_out),
    .col_valid   (col_valid),
    .col_x       (col_x),
    .col_y       (col_y),
    .win_full    (win_full),
    .frame_done  (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: keeps every pixel of the current frame and reads the column directly.
  task automatic model_step(input logic fs, input logic v, input logic p, output exp_t e);
    e = '0;
    if (fs) begin
      m_act = 1'b1;
      m_x = 0;
      m_y = 0;
    end
    if (v && m_act) begin
      fb[m_y][m_x] = p;
      e.v    = 1'b1;
      e.x    = 3'(m_x);
      e.y    = 3'(m_y);
      e.full = (m_y >= 4);
      e.done = (m_x == W - 1) && (m_y == H - 1);
      for (int k = 0; k < 5; k++) begin
        e.col[k] = (m_y >= k) ? fb[m_y - k][m_x] : PAD;
      end
      if (e.done) m_act = 1'b0;
      if (m_x == W - 1) begin
        m_x = 0;
        m_y++;
      end else begin
        m_x++;
      end
    end
  endtask

  task automatic drive(input logic fs, input logic v, input logic p, input exp_t e);
    exp_t cur;
    frame_start = fs;
    pix_valid   = v;
    pix_in      = p;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    pix_in      = 1'b0;
    if (q.size() >= 2) begin
      cur = q.pop_front();
      if (frame_done) done_cnt++;
      chk("col_valid", 32'(col_valid), 32'(cur.v));
      if (cur.v) begin
        chk("col_out", 32'(col_out), 32'(cur.col));
        chk("col_x", 32'(col_x), 32'(cur.x));
        chk("col_y", 32'(col_y), 32'(cur.y));
        chk("win_full", 32'(win_full), 32'(cur.full));
        chk("frame_done", 32'(frame_done), 32'(cur.done));
      end else begin
        chk("win_full_idle", 32'(win_full), 32'd0);
        chk("frame_done_idle", 32'(frame_done), 32'd0);
      end
    end
  endtask

  task automatic px(input logic fs, input logic v, input logic p);
    exp_t e;
    model_step(fs, v, p, e);
    drive(fs, v, p, e);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_col_out"}, 32'(col_out), 32'd0);
    chk({tag, "_col_valid"}, 32'(col_valid), 32'd0);
    chk({tag, "_col_x"}, 32'(col_x), 32'd0);
    chk({tag, "_col_y"}, 32'(col_y), 32'd0);
    chk({tag, "_win_full"}, 32'(win_full), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
  endtask

  initial begin
    exp_t dummy;
    int   rows[5] = '{1, 0, 1, 1, 0};

    // Test 1 vectors: frame_start, then a line of 1s at y=0.
    tbl[0] = '0;
    tbl[0].fs = 1'b1;
    for (int i = 1; i < 9; i++) begin
      tbl[i]       = '0;
      tbl[i].v     = 1'b1;
      tbl[i].p     = 1'b1;
      tbl[i].e.v   = 1'b1;
      tbl[i].e.col = ROW0_ONES;
      tbl[i].e.x   = 3'(i - 1);
      tbl[i].e.y   = 3'd0;
    end

    rst = 1'b1;
    frame_start = 1'b0;
    pix_valid = 1'b0;
    pix_in = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      model_step(tbl[i].fs, tbl[i].v, tbl[i].p, dummy);
      drive(tbl[i].fs, tbl[i].v, tbl[i].p, tbl[i].e);
    end

    // Test 3: bubbles across line 1.
    for (int i = 0; i < 2 * W; i++) px(1'b0, (i % 2) == 0, 1'b1);

    // Test 4: rest of frame, then pixels after the end must be ignored.
    for (int i = 0; i < (H - 2) * W; i++) px(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) px(1'b0, 1'b1, 1'b1);
    chk("frame_done_count", 32'(done_cnt), 32'd1);

    // Test 2: constant lines 1,0,1,1,0 over a RAM full of stale 1s.
    px(1'b1, 1'b0, 1'b0);
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < W; c++) px(1'b0, 1'b1, rows[r][0]);
    end
    px(1'b0, 1'b0, 1'b0);
    px(1'b0, 1'b0, 1'b0);

    // Test 5: random frame, restart coincident with pixel (3,4).
    px(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4 * W + 3; i++) px(1'b0, 1'b1, 1'($urandom_range(1, 0)));
    px(1'b1, 1'b1, 1'b1);
    px(1'b0, 1'b1, 1'b0);
    px(1'b0, 1'b1, 1'b1);

    // Test 6: async reset between clock edges, then pixels ignored until frame_start.
    px(1'b0, 1'b1, 1'b1);
    #2 rst = 1'b1;
    #1 chk_zero_outputs("async_rst");
    q.delete();
    m_act = 1'b0;
    m_x = 0;
    m_y = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) px(1'b0, 1'b1, 1'b1);
    px(1'b1, 1'b1, 1'b1);
    px(1'b0, 1'b1, 1'b0);
    px(1'b0, 1'b0, 1'b0);
    px(1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
